pipe_ctrl: RTL and testbench

Central pipeline controller for the 6-stage MIPS core. It merges stall requests from the IF, ID, EX and MEM stages into the stall[5:0] vector consumed by every pipeline register. It sequences exception/ERET flushes: freeze, then a one-cycle flush with the redirect PC. It also keeps a stall-cycle performance counter and a stall watchdog.

---
 rtl/pipe_ctrl.sv | 97 +++++++++
 tb/tb_pipe_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with stall counter and watchdog
module pipe_ctrl #(
    parameter logic [31:0]       EXC_VECTOR = 32'h0000_0020,
    parameter int                WDOG_W     = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdog_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [31:0] ERET_TYPE = 32'h0000_000e;

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_exc;
    logic                w_req;
    logic                w_wd_inc;
    logic [WDOG_W-1:0]   r_wd_cnt;
    logic [WDOG_W-1:0]   w_wd_nxt;

    assign w_req = stallreq_from_if | stallreq_from_id | stallreq_from_ex | stallreq_from_mem;

    always_comb begin
        w_state_nxt = r_state;
        w_exc       = 1'b0;
        stall       = 6'b000000;
        case (r_state)
            S_RUN: begin
                // An exception freezes everything so the faulting instruction never commits.
                if (excepttype_i != 32'd0) begin
                    w_exc       = 1'b1;
                    stall       = 6'b111111;
                    w_state_nxt = S_FLUSH;
                end else if (stallreq_from_mem) begin
                    stall = 6'b011111;
                end else if (stallreq_from_ex) begin
                    stall = 6'b001111;
                end else if (stallreq_from_id || stallreq_from_if) begin
                    stall = 6'b000111;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign flush = (r_state == S_FLUSH);

    assign w_wd_inc = (r_state == S_RUN) && !w_exc && w_req;

    always_comb begin
        w_wd_nxt = '0;
        if (w_wd_inc) begin
            w_wd_nxt = (r_wd_cnt == {WDOG_W{1'b1}}) ? r_wd_cnt : r_wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            new_pc      <= 32'd0;
            r_wd_cnt    <= '0;
            wdog_o      <= 1'b0;
            stall_cnt_o <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_wd_cnt <= w_wd_nxt;
            if (w_exc) begin
                new_pc <= (excepttype_i == ERET_TYPE) ? cp0_epc_i : EXC_VECTOR;
            end
            if (w_wd_inc && (w_wd_nxt >= WDOG_LIMIT)) begin
                wdog_o <= 1'b1;
            end
            if (stall[0]) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdog_o;
    logic [31:0] stall_cnt_o;

    int n_tests;
    int n_fail;
    logic [31:0] exp_cnt;

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .WDOG_W     (16),
        .WDOG_LIMIT (16'd4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .excepttype_i      (excepttype_i),
        .cp0_epc_i         (cp0_epc_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .wdog_o            (wdog_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic set_req(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem);
        stallreq_from_if  = i_if;
        stallreq_from_id  = i_id;
        stallreq_from_ex  = i_ex;
        stallreq_from_mem = i_mem;
    endtask

    logic [3:0] req_vec  [4];
    logic [5:0] stall_exp[4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 32'd0;
        rst = 1'b1;
        set_req(0, 0, 0, 0);
        excepttype_i = 32'd0;
        cp0_epc_i    = 32'd0;

        // {if,id,ex,mem}
        req_vec[0] = 4'b0100; stall_exp[0] = 6'b000111;
        req_vec[1] = 4'b0010; stall_exp[1] = 6'b001111;
        req_vec[2] = 4'b0001; stall_exp[2] = 6'b011111;
        req_vec[3] = 4'b1000; stall_exp[3] = 6'b000111;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {26'd0, stall}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_wdog", {31'd0, wdog_o}, 32'd0);
        chk("rst_cnt", stall_cnt_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                set_req(req_vec[k][3], req_vec[k][2], req_vec[k][1], req_vec[k][0]);
                #1;
                chk($sformatf("single%0d_stall", k), {26'd0, stall}, {26'd0, stall_exp[k]});
            end
            @(negedge clk);
            set_req(0, 0, 0, 0);
            #1;
            exp_cnt = exp_cnt + 32'd3;
            chk($sformatf("single%0d_cnt", k), stall_cnt_o, exp_cnt);
            chk($sformatf("single%0d_idle", k), {26'd0, stall}, 32'd0);
        end
        chk("single_wdog", {31'd0, wdog_o}, 32'd0);

        @(negedge clk);
        set_req(0, 1, 1, 1);
        #1;
        chk("prio_all", {26'd0, stall}, 32'h1f);
        stallreq_from_mem = 1'b0;
        #1;
        chk("prio_nomem", {26'd0, stall}, 32'h0f);
        @(negedge clk);
        set_req(0, 0, 0, 0);
        #1;
        exp_cnt = exp_cnt + 32'd1;
        chk("prio_cnt", stall_cnt_o, exp_cnt);

        @(negedge clk);
        excepttype_i = 32'h8;
        #1;
        chk("exc_hold_stall", {26'd0, stall}, 32'h3f);
        chk("exc_hold_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        #1;
        exp_cnt = exp_cnt + 32'd1;
        chk("exc_flush", {31'd0, flush}, 32'd1);
        chk("exc_new_pc", new_pc, 32'h20);
        chk("exc_flush_stall", {26'd0, stall}, 32'd0);
        chk("exc_cnt", stall_cnt_o, exp_cnt);
        @(negedge clk);
        excepttype_i = 32'd0;
        #1;
        chk("exc_after_flush", {31'd0, flush}, 32'd0);
        chk("exc_after_cnt", stall_cnt_o, exp_cnt);

        @(negedge clk);
        cp0_epc_i    = 32'h0000_1234;
        excepttype_i = 32'he;
        stallreq_from_mem = 1'b1;
        #1;
        chk("eret_hold_stall", {26'd0, stall}, 32'h3f);
        @(negedge clk);
        excepttype_i = 32'd0;
        #1;
        exp_cnt = exp_cnt + 32'd1;
        chk("eret_flush", {31'd0, flush}, 32'd1);
        chk("eret_new_pc", new_pc, 32'h1234);
        chk("eret_flush_stall", {26'd0, stall}, 32'd0);
        @(negedge clk);
        stallreq_from_mem = 1'b0;
        cp0_epc_i = 32'h0000_5678;
        #1;
        chk("eret_done", {31'd0, flush}, 32'd0);
        chk("eret_pc_hold", new_pc, 32'h1234);
        chk("eret_cnt", stall_cnt_o, exp_cnt);

        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                stallreq_from_ex = 1'b1;
            end
            @(negedge clk);
            stallreq_from_ex = 1'b0;
            #1;
            chk($sformatf("wd_gap%0d", g), {31'd0, wdog_o}, 32'd0);
        end
        exp_cnt = exp_cnt + 32'd6;

        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            stallreq_from_ex = 1'b1;
            #1;
            chk($sformatf("wd_run%0d", c), {31'd0, wdog_o}, 32'd0);
        end
        @(negedge clk);
        stallreq_from_ex = 1'b0;
        #1;
        exp_cnt = exp_cnt + 32'd4;
        chk("wd_set", {31'd0, wdog_o}, 32'd1);
        @(negedge clk);
        #1;
        chk("wd_sticky", {31'd0, wdog_o}, 32'd1);
        chk("wd_cnt", stall_cnt_o, exp_cnt);

        @(negedge clk);
        excepttype_i = 32'h8;
        @(negedge clk);
        excepttype_i = 32'd0;
        #1;
        chk("rst_mid_flush_pre", {31'd0, flush}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_flush", {31'd0, flush}, 32'd0);
        chk("rst_mid_new_pc", new_pc, 32'd0);
        chk("rst_mid_cnt", stall_cnt_o, 32'd0);
        chk("rst_mid_wdog", {31'd0, wdog_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_after", {31'd0, flush}, 32'd0);
        chk("rst_mid_after_stall", {26'd0, stall}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
